wx_load_sequencer: RTL and testbench
====================================

// Module: wx_load_sequencer
// PURPOSE
//  Hardware replacement for the bench-driven load sequence of mnist_nn. Consumes a
//  serial valid/ready bit stream and writes it into NUM_WBANK weight banks and the
//  input bank in order, each bank with a runtime length. It then hands the memories
//  to the compute datapath (load_compute_ctrl 1->0), raises en_compute and waits for
//  compute_finish, with a watchdog.
// PARAMETERS
//  NUM_WBANK   4      number of weight banks, selected by w_sel_oc = 0..NUM_WBANK-1
//  W_ADDR_LEN  20     weight address width
//  X_ADDR_LEN  10     input address width
//  W_SEL_LEN   2      weight bank select width; must satisfy 2**W_SEL_LEN >= NUM_WBANK
//  X_SEL_LEN   2      input bank select width
//  DATA_LEN    1      stream/memory data width
//  X_SEL_LOAD  0      input bank that receives the input image
//  TIMEOUT     65535  maximum en_compute cycles before err; 0 disables the watchdog
// PORTS
//  clk               in   1                     clock
//  rst               in   1                     asynchronous reset, active-high
//  start             in   1                     1-cycle pulse; sampled only in IDLE
//  w_len             in   NUM_WBANK*W_ADDR_LEN  per-bank word counts, bank k at [k*W_ADDR_LEN +: W_ADDR_LEN]; sampled on start
//  x_len             in   X_ADDR_LEN            input word count; sampled on start
//  s_valid           in   1                     stream beat valid
//  s_data            in   DATA_LEN              stream beat data
//  s_ready           out  1                     stream beat accepted when s_valid & s_ready
//  w_wq_oc           out  1                     weight write enable
//  w_addr_oc         out  W_ADDR_LEN            weight write address
//  w_sel_oc          out  W_SEL_LEN             weight bank select
//  x_wq_oc           out  1                     input write enable
//  x_addr_oc         out  X_ADDR_LEN            input write address
//  x_sel_oc          out  X_SEL_LEN             input bank select
//  wx_write_oc       out  DATA_LEN              shared write data
//  load_compute_ctrl out  1                     1 = load mode, 0 = compute owns the memories
//  en_compute        out  1                     compute enable
//  compute_finish    in   1                     from the compute datapath
//  busy              out  1                     high in every state except IDLE
//  done              out  1                     1-cycle pulse when compute completes
//  err               out  1                     sticky watchdog error; cleared by the next accepted start
// BEHAVIOUR
//  - Reset (async): state IDLE, load_compute_ctrl=1, every other output 0, counters 0.
//    Reset mid-operation abandons the load; memory contents are not rolled back.
//  - All outputs are registered. An accepted beat appears as a write on the next cycle:
//    wq=1 for 1 cycle, with addr, sel and wx_write_oc valid in the same cycle.
//  - FSM: IDLE -> LOAD_W -> LOAD_X -> HANDOFF -> COMPUTE -> FIN -> IDLE.
//  - IDLE: s_ready=0. start latches w_len/x_len, sets bank=0, addr=0, clears err,
//    then goes to LOAD_W. A start seen outside IDLE is ignored.
//  - LOAD_W: s_ready=1. Each accepted beat writes bank `bank`, address addr, then addr++.
//    When addr reaches w_len[bank]-1: addr=0 and bank++. Banks with w_len=0 are skipped
//    without using any cycle. After the last bank the FSM goes to LOAD_X.
//    No bubble between banks; a beat is accepted every cycle when s_valid stays high.
//  - LOAD_X: same rules into x_sel_oc=X_SEL_LOAD. x_len=0 skips directly to HANDOFF.
//  - HANDOFF: s_ready=0. load_compute_ctrl drops to 0 one cycle after the final write
//    pulse; en_compute rises the cycle after that.
//  - COMPUTE: en_compute is held 1 until compute_finish is sampled 1, then goes to FIN.
//    A watchdog counts cycles; when the count reaches TIMEOUT: err=1, en_compute=0,
//    go to FIN.
//  - FIN: done=1 for 1 cycle (also on timeout), en_compute=0, load_compute_ctrl=1,
//    then IDLE.
//  - compute_finish outside COMPUTE is ignored.
//  - s_valid outside LOAD_* is ignored; the beat is not consumed.
//  - Address counters never wrap. An over-range length is truncated to the bit width.
// TESTING
//  1 Lengths {6,9,9,9}, x_len=2, s_valid held 1 -> 35 writes: sel0 a0..5, sel1..3 a0..8,
//    then x a0..1. load_compute_ctrl falls 1 cycle after the last write; en_compute
//    rises 1 cycle later.
//  2 Toggle s_valid randomly, same lengths -> identical write sequence and data order,
//    and no write in any cycle following a non-accepted beat.
//  3 w_len={0,3,0,2}, x_len=0 -> writes only sel1 a0..2 and sel3 a0..1, then HANDOFF;
//    x_wq_oc never asserts.
//  4 compute_finish asserted 10 cycles after en_compute -> en_compute drops, done pulses
//    once, busy=0 the next cycle. With TIMEOUT=16 and no finish -> err=1, done pulses,
//    err remains 1 until the next start.
//  5 rst asserted mid-LOAD_W (bank 2, addr 4) -> all outputs at reset values immediately;
//    a new start reloads from bank 0, addr 0.
//  6 start pulsed during LOAD_X and during COMPUTE -> no effect on state or counters.

Source files
------------

// File: rtl/wx_load_sequencer_if.sv
// Serial load stream: valid/ready handshake with one data beat per transfer.
// The sequencer is the slave side; the stream source is the master.
interface wx_load_sequencer_if #(
  parameter int DATA_LEN = 1
);
  logic                s_valid;
  logic [DATA_LEN-1:0] s_data;
  logic                s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/wx_load_sequencer.sv
// Streams weights and input image into the wx memories, then hands them
// to the compute datapath and waits for it to finish, under a watchdog.
module wx_load_sequencer #(
  parameter int NUM_WBANK  = 4,
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int W_SEL_LEN  = 2,
  parameter int X_SEL_LEN  = 2,
  parameter int DATA_LEN   = 1,
  parameter int X_SEL_LOAD = 0,
  parameter int TIMEOUT    = 65535
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_WBANK*W_ADDR_LEN-1:0] w_len,
  input  logic [X_ADDR_LEN-1:0]           x_len,
  wx_load_sequencer_if.slave              s,
  output logic                            w_wq_oc,
  output logic [W_ADDR_LEN-1:0]           w_addr_oc,
  output logic [W_SEL_LEN-1:0]            w_sel_oc,
  output logic                            x_wq_oc,
  output logic [X_ADDR_LEN-1:0]           x_addr_oc,
  output logic [X_SEL_LEN-1:0]            x_sel_oc,
  output logic [DATA_LEN-1:0]             wx_write_oc,
  output logic                            load_compute_ctrl,
  output logic                            en_compute,
  input  logic                            compute_finish,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int LW = NUM_WBANK * W_ADDR_LEN;
  localparam int SW = W_SEL_LEN + 1;
  localparam logic [SW-1:0] NB = SW'(NUM_WBANK);
  localparam int WD = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD-1:0] WD_LAST = WD'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_X,
    S_HANDOFF,
    S_COMPUTE,
    S_FIN
  } state_t;

  // First bank at or above `from` with a non-zero length, NB if none.
  function automatic logic [SW-1:0] first_nz(
    input logic [SW-1:0] from,
    input logic [LW-1:0] lens
  );
    logic [SW-1:0] r;
    r = NB;
    for (int k = NUM_WBANK - 1; k >= 0; k--) begin
      if (SW'(k) >= from &&
          lens[k*W_ADDR_LEN +: W_ADDR_LEN] != '0)
        r = SW'(k);
    end
    return r;
  endfunction

  function automatic logic [W_ADDR_LEN-1:0] len_of(
    input logic [SW-1:0] b,
    input logic [LW-1:0] lens
  );
    logic [W_ADDR_LEN-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_WBANK; k++) begin
      if (SW'(k) == b)
        r = lens[k*W_ADDR_LEN +: W_ADDR_LEN];
    end
    return r;
  endfunction

  state_t r_state;
  state_t w_nxt;

  logic [LW-1:0]         r_wlen;
  logic [X_ADDR_LEN-1:0] r_xlen;
  logic [SW-1:0]         r_bank;
  logic [W_ADDR_LEN-1:0] r_addr;
  logic [X_ADDR_LEN-1:0] r_xaddr;
  logic [WD-1:0]         r_wd;

  logic                  r_s_ready;
  logic                  r_w_wq;
  logic [W_ADDR_LEN-1:0] r_w_addr;
  logic [W_SEL_LEN-1:0]  r_w_sel;
  logic                  r_x_wq;
  logic [X_ADDR_LEN-1:0] r_x_addr;
  logic [X_SEL_LEN-1:0]  r_x_sel;
  logic [DATA_LEN-1:0]   r_wdata;
  logic                  r_lcc;
  logic                  r_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_acc;
  logic [W_ADDR_LEN-1:0] w_cur_len;
  logic                  w_w_last;
  logic                  w_x_last;
  logic [SW-1:0]         w_nb0;
  logic [SW-1:0]         w_nbn;
  logic                  w_wd_hit;
  logic                  w_go;

  logic                  w_d_s_ready;
  logic                  w_d_w_wq;
  logic                  w_d_x_wq;
  logic                  w_d_lcc;
  logic                  w_d_en;
  logic                  w_d_busy;
  logic                  w_d_done;
  logic                  w_d_err;

  assign w_acc     = s.s_valid & r_s_ready;
  assign w_cur_len = len_of(r_bank, r_wlen);
  assign w_w_last  = r_addr == w_cur_len - W_ADDR_LEN'(1);
  assign w_x_last  = r_xaddr == r_xlen - X_ADDR_LEN'(1);
  assign w_nb0     = first_nz('0, w_len);
  assign w_nbn     = first_nz(r_bank + SW'(1), r_wlen);
  assign w_wd_hit  = (TIMEOUT != 0) && (r_wd == WD_LAST);
  // compute_finish only counts once en_compute is actually up
  assign w_go      = r_en && (compute_finish || w_wd_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_nb0 != NB)      w_nxt = S_LOAD_W;
          else if (x_len != '0) w_nxt = S_LOAD_X;
          else                  w_nxt = S_HANDOFF;
        end
      end
      S_LOAD_W: begin
        if (w_acc && w_w_last && w_nbn == NB)
          w_nxt = (r_xlen != '0) ? S_LOAD_X : S_HANDOFF;
      end
      S_LOAD_X: begin
        if (w_acc && w_x_last) w_nxt = S_HANDOFF;
      end
      S_HANDOFF: w_nxt = S_COMPUTE;
      S_COMPUTE: begin
        if (w_go) w_nxt = S_FIN;
      end
      S_FIN:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_d_s_ready = (w_nxt == S_LOAD_W) || (w_nxt == S_LOAD_X);
    w_d_w_wq    = (r_state == S_LOAD_W) && w_acc;
    w_d_x_wq    = (r_state == S_LOAD_X) && w_acc;
    w_d_busy    = w_nxt != S_IDLE;
    w_d_done    = (r_state == S_COMPUTE) && w_go;
    w_d_lcc     = r_lcc;
    w_d_en      = r_en;
    w_d_err     = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_d_err = 1'b0;
      end
      S_HANDOFF: w_d_lcc = 1'b0;
      S_COMPUTE: begin
        if (!r_en) begin
          w_d_en = 1'b1;
        end else if (w_go) begin
          w_d_en  = 1'b0;
          w_d_lcc = 1'b1;
          if (!compute_finish) w_d_err = 1'b1;
        end
      end
      S_FIN: begin
        w_d_en  = 1'b0;
        w_d_lcc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wlen    <= '0;
      r_xlen    <= '0;
      r_bank    <= '0;
      r_addr    <= '0;
      r_xaddr   <= '0;
      r_wd      <= '0;
      r_s_ready <= 1'b0;
      r_w_wq    <= 1'b0;
      r_w_addr  <= '0;
      r_w_sel   <= '0;
      r_x_wq    <= 1'b0;
      r_x_addr  <= '0;
      r_x_sel   <= '0;
      r_wdata   <= '0;
      r_lcc     <= 1'b1;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_s_ready <= w_d_s_ready;
      r_w_wq    <= w_d_w_wq;
      r_x_wq    <= w_d_x_wq;
      r_lcc     <= w_d_lcc;
      r_en      <= w_d_en;
      r_busy    <= w_d_busy;
      r_done    <= w_d_done;
      r_err     <= w_d_err;

      if (r_state == S_IDLE && start) begin
        r_wlen  <= w_len;
        r_xlen  <= x_len;
        r_bank  <= w_nb0;
        r_addr  <= '0;
        r_xaddr <= '0;
      end

      // Empty banks are stepped over in the same cycle as the last beat
      if (w_d_w_wq) begin
        r_w_addr <= r_addr;
        r_w_sel  <= r_bank[W_SEL_LEN-1:0];
        r_wdata  <= s.s_data;
        if (w_w_last) begin
          r_addr <= '0;
          r_bank <= w_nbn;
        end else begin
          r_addr <= r_addr + W_ADDR_LEN'(1);
        end
      end

      if (w_d_x_wq) begin
        r_x_addr <= r_xaddr;
        r_x_sel  <= X_SEL_LEN'(X_SEL_LOAD);
        r_wdata  <= s.s_data;
        r_xaddr  <= w_x_last ? '0 : r_xaddr + X_ADDR_LEN'(1);
      end

      if (r_state == S_COMPUTE && r_en) r_wd <= r_wd + WD'(1);
      else                              r_wd <= '0;
    end
  end

  assign s.s_ready         = r_s_ready;
  assign w_wq_oc           = r_w_wq;
  assign w_addr_oc         = r_w_addr;
  assign w_sel_oc          = r_w_sel;
  assign x_wq_oc           = r_x_wq;
  assign x_addr_oc         = r_x_addr;
  assign x_sel_oc          = r_x_sel;
  assign wx_write_oc       = r_wdata;
  assign load_compute_ctrl = r_lcc;
  assign en_compute        = r_en;
  assign busy              = r_busy;
  assign done              = r_done;
  assign err               = r_err;

endmodule

// File: tb/tb_wx_load_sequencer.sv
// Bench for wx_load_sequencer: random stream stimulus against a
// bank-by-bank write list built from the programmed lengths.
module tb_wx_load_sequencer;

  localparam int NW   = 4;
  localparam int WA   = 20;
  localparam int XA   = 10;
  localparam int WS   = 2;
  localparam int XS   = 2;
  localparam int DL   = 1;
  localparam int XSEL = 2;
  localparam int TO   = 16;

  typedef int lens_t[NW];

  typedef struct {
    bit x;
    int sel;
    int addr;
    bit d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NW*WA-1:0]  w_len;
  logic [XA-1:0]     x_len;
  logic              w_wq_oc;
  logic [WA-1:0]     w_addr_oc;
  logic [WS-1:0]     w_sel_oc;
  logic              x_wq_oc;
  logic [XA-1:0]     x_addr_oc;
  logic [XS-1:0]     x_sel_oc;
  logic [DL-1:0]     wx_write_oc;
  logic              load_compute_ctrl;
  logic              en_compute;
  logic              compute_finish;
  logic              busy;
  logic              done;
  logic              err;

  wx_load_sequencer_if #(.DATA_LEN(DL)) sif ();

  wx_load_sequencer #(
    .NUM_WBANK (NW),
    .W_ADDR_LEN(WA),
    .X_ADDR_LEN(XA),
    .W_SEL_LEN (WS),
    .X_SEL_LEN (XS),
    .DATA_LEN  (DL),
    .X_SEL_LOAD(XSEL),
    .TIMEOUT   (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .w_len            (w_len),
    .x_len            (x_len),
    .s                (sif.slave),
    .w_wq_oc          (w_wq_oc),
    .w_addr_oc        (w_addr_oc),
    .w_sel_oc         (w_sel_oc),
    .x_wq_oc          (x_wq_oc),
    .x_addr_oc        (x_addr_oc),
    .x_sel_oc         (x_sel_oc),
    .wx_write_oc      (wx_write_oc),
    .load_compute_ctrl(load_compute_ctrl),
    .en_compute       (en_compute),
    .compute_finish   (compute_finish),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  int  drv_mode;
  bit  mon_on;
  int  cyc;
  int  viol;
  int  first_wr;
  int  last_wr;
  int  lcc_fall;
  int  en_rise;
  int  en_hi;
  int  done_cnt;
  int  n_xwr;
  bit  acc;
  bit  prev_acc;
  bit  prev_lcc;
  bit  prev_en;
  wr_t obs[$];
  wr_t exp_q[$];
  bit  beats[$];

  // Stream source: 0 idle, 1 valid held high, 2 random valid
  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      case (drv_mode)
        0:       sif.s_valid = 1'b0;
        1:       sif.s_valid = 1'b1;
        default: sif.s_valid = 1'($urandom_range(0, 1));
      endcase
      sif.s_data = DL'($urandom);
    end
  end

  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      acc = sif.s_valid & sif.s_ready;
      if (mon_on) begin
        if (w_wq_oc) begin
          obs.push_back('{1'b0, int'(w_sel_oc), int'(w_addr_oc),
                          wx_write_oc[0]});
          if (!prev_acc) viol++;
          if (first_wr < 0) first_wr = cyc;
          last_wr = cyc;
        end
        if (x_wq_oc) begin
          obs.push_back('{1'b1, int'(x_sel_oc), int'(x_addr_oc),
                          wx_write_oc[0]});
          if (!prev_acc) viol++;
          if (first_wr < 0) first_wr = cyc;
          last_wr = cyc;
          n_xwr++;
        end
        if (w_wq_oc && x_wq_oc) viol++;
        if (acc) beats.push_back(sif.s_data[0]);
        if (prev_lcc && !load_compute_ctrl) lcc_fall = cyc;
        if (!prev_en && en_compute) en_rise = cyc;
        if (en_compute) en_hi++;
        if (done) done_cnt++;
      end
      prev_acc = acc;
      prev_lcc = load_compute_ctrl;
      prev_en  = en_compute;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_mon();
    obs.delete();
    beats.delete();
    viol     = 0;
    first_wr = -1;
    last_wr  = -1;
    lcc_fall = -1;
    en_rise  = -1;
    en_hi    = 0;
    done_cnt = 0;
    n_xwr    = 0;
    mon_on   = 1'b1;
  endtask

  task automatic build_exp(input lens_t l, input int xl);
    exp_q.delete();
    for (int k = 0; k < NW; k++)
      for (int a = 0; a < l[k]; a++)
        exp_q.push_back('{1'b0, k, a, 1'b0});
    for (int a = 0; a < xl; a++)
      exp_q.push_back('{1'b1, XSEL, a, 1'b0});
  endtask

  task automatic do_start(input lens_t l, input int xl);
    @(posedge clk);
    #1;
    for (int k = 0; k < NW; k++)
      w_len[k*WA +: WA] = WA'(l[k]);
    x_len = XA'(xl);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      if (en_compute) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (load_compute_ctrl !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_lcc: got %b want 1", load_compute_ctrl);
    end
    n_chk++;
    if ({w_wq_oc, x_wq_oc, en_compute, busy, done, err, sif.s_ready}
        !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000000",
               {w_wq_oc, x_wq_oc, en_compute, busy, done, err,
                sif.s_ready});
    end
    n_chk++;
    if ({w_addr_oc, w_sel_oc, x_addr_oc, x_sel_oc, wx_write_oc} !== '0)
    begin
      n_fail++;
      $display("FAIL reset_bus: got w%0d/%0d x%0d/%0d d%0d want zeros",
               w_addr_oc, w_sel_oc, x_addr_oc, x_sel_oc, wx_write_oc);
    end
    rst = 1'b0;
    drv_mode = 1;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({sif.s_ready, w_wq_oc, x_wq_oc, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_valid: got %b want 0000",
               {sif.s_ready, w_wq_oc, x_wq_oc, busy});
    end
    drv_mode = 0;
  endtask

  task automatic test_stream(input string name, input lens_t l,
                             input int xl, input int mode,
                             input int fd);
    bit ok;
    build_exp(l, xl);
    clear_mon();
    drv_mode = mode;
    do_start(l, xl);
    wait_en(ok);
    drv_mode = 0;
    n_chk++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s en_wait: en_compute %b want 1 within bound",
               name, en_compute);
    end
    n_chk++;
    if (obs.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s n_writes: got %0d want %0d",
               name, obs.size(), exp_q.size());
    end
    n_chk++;
    if (beats.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s n_beats: got %0d want %0d",
               name, beats.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size()
                    && i < beats.size(); i++) begin
      n_chk++;
      if (obs[i].x !== exp_q[i].x || obs[i].sel !== exp_q[i].sel ||
          obs[i].addr !== exp_q[i].addr || obs[i].d !== beats[i]) begin
        n_fail++;
        $display("FAIL %s wr[%0d]: got x%0d s%0d a%0d d%0d want x%0d s%0d a%0d d%0d",
                 name, i, obs[i].x, obs[i].sel, obs[i].addr, obs[i].d,
                 exp_q[i].x, exp_q[i].sel, exp_q[i].addr, beats[i]);
      end
    end
    n_chk++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL %s write_without_beat: got %0d want 0", name, viol);
    end
    n_chk++;
    if (n_xwr !== xl) begin
      n_fail++;
      $display("FAIL %s x_writes: got %0d want %0d", name, n_xwr, xl);
    end
    if (mode == 1 && exp_q.size() > 0) begin
      n_chk++;
      if (last_wr - first_wr + 1 !== exp_q.size()) begin
        n_fail++;
        $display("FAIL %s no_bubble: span %0d want %0d",
                 name, last_wr - first_wr + 1, exp_q.size());
      end
    end
    if (exp_q.size() > 0) begin
      n_chk++;
      if (lcc_fall !== last_wr + 1) begin
        n_fail++;
        $display("FAIL %s lcc_fall: cycle %0d want %0d",
                 name, lcc_fall, last_wr + 1);
      end
    end
    n_chk++;
    if (en_rise !== lcc_fall + 1) begin
      n_fail++;
      $display("FAIL %s en_rise: cycle %0d want %0d",
               name, en_rise, lcc_fall + 1);
    end
    n_chk++;
    if ({sif.s_ready, load_compute_ctrl, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL %s compute_state: rdy/lcc/busy %b want 001",
               name, {sif.s_ready, load_compute_ctrl, busy});
    end
    repeat (fd) @(posedge clk);
    #1;
    compute_finish = 1'b1;
    @(posedge clk);
    #1;
    compute_finish = 1'b0;
    n_chk++;
    if ({en_compute, done, busy, load_compute_ctrl} !== 4'b0111) begin
      n_fail++;
      $display("FAIL %s fin: en/done/busy/lcc %b want 0111",
               name, {en_compute, done, busy, load_compute_ctrl});
    end
    @(posedge clk);
    #1;
    n_chk++;
    if ({done, busy, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s idle_after: done/busy/err %b want 000",
               name, {done, busy, err});
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
    end
    n_chk++;
    if (en_hi !== fd + 1) begin
      n_fail++;
      $display("FAIL %s en_cycles: got %0d want %0d", name, en_hi, fd + 1);
    end
    mon_on = 1'b0;
  endtask

  task automatic test_full_stream();
    lens_t l;
    l = '{6, 9, 9, 9};
    test_stream("held_valid", l, 2, 1, 10);
  endtask

  task automatic test_random_valid();
    lens_t l;
    l = '{6, 9, 9, 9};
    test_stream("random_valid", l, 2, 2, 10);
  endtask

  task automatic test_skip_banks();
    lens_t l;
    l = '{0, 3, 0, 2};
    test_stream("skip_banks", l, 0, 2, 3);
  endtask

  task automatic test_random_lengths();
    lens_t l;
    for (int it = 0; it < 5; it++) begin
      for (int k = 0; k < NW; k++) l[k] = int'($urandom_range(0, 5));
      test_stream($sformatf("rand_len%0d", it), l,
                  int'($urandom_range(0, 4)), 1 + it % 2,
                  int'($urandom_range(0, 6)));
    end
  endtask

  task automatic test_back_to_back();
    lens_t l;
    l = '{1, 0, 0, 0};
    test_stream("b2b_a", l, 1, 1, 0);
    l = '{0, 0, 0, 1};
    test_stream("b2b_b", l, 0, 1, 0);
    l = '{0, 0, 0, 0};
    test_stream("b2b_empty", l, 0, 0, 1);
  endtask

  task automatic test_timeout();
    lens_t l;
    bit ok;
    bit dropped;
    l = '{2, 0, 1, 0};
    clear_mon();
    drv_mode = 1;
    do_start(l, 1);
    wait_en(ok);
    drv_mode = 0;
    dropped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (!en_compute) begin
        dropped = 1'b1;
        break;
      end
    end
    n_chk++;
    if ({ok, dropped} !== 2'b11) begin
      n_fail++;
      $display("FAIL wd_events: en_up/en_down %b want 11", {ok, dropped});
    end
    n_chk++;
    if (en_hi !== TO) begin
      n_fail++;
      $display("FAIL wd_en_cycles: got %0d want %0d", en_hi, TO);
    end
    n_chk++;
    if ({err, done, busy, load_compute_ctrl} !== 4'b1111) begin
      n_fail++;
      $display("FAIL wd_fin: err/done/busy/lcc %b want 1111",
               {err, done, busy, load_compute_ctrl});
    end
    repeat (5) @(negedge clk);
    #1;
    compute_finish = 1'b1;
    @(negedge clk);
    #1;
    compute_finish = 1'b0;
    n_chk++;
    if ({err, busy, done_cnt} !== {1'b1, 1'b0, 32'sd1}) begin
      n_fail++;
      $display("FAIL wd_sticky: err %b busy %b done_cnt %0d want 1 0 1",
               err, busy, done_cnt);
    end
    l = '{1, 0, 0, 0};
    drv_mode = 1;
    do_start(l, 0);
    n_chk++;
    if ({err, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL wd_clear_on_start: err/busy %b want 01", {err, busy});
    end
    wait_en(ok);
    drv_mode = 0;
    @(posedge clk);
    #1;
    compute_finish = 1'b1;
    @(posedge clk);
    #1;
    compute_finish = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({ok, busy, err} !== 3'b100) begin
      n_fail++;
      $display("FAIL wd_recover: en_up/busy/err %b want 100",
               {ok, busy, err});
    end
    mon_on = 1'b0;
  endtask

  task automatic test_reset_mid();
    lens_t l;
    bit hit;
    l = '{6, 9, 9, 9};
    clear_mon();
    drv_mode = 1;
    do_start(l, 2);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (w_wq_oc && w_sel_oc == 2'd2 && w_addr_oc == 20'd3) begin
        hit = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (hit !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_reach: got %b want 1", hit);
    end
    n_chk++;
    if ({load_compute_ctrl, sif.s_ready, w_wq_oc, busy, en_compute}
        !== 5'b10000) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: lcc/rdy/wq/busy/en %b want 10000",
               {load_compute_ctrl, sif.s_ready, w_wq_oc, busy,
                en_compute});
    end
    n_chk++;
    if ({w_addr_oc, w_sel_oc} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_bus: addr %0d sel %0d want 0 0",
               w_addr_oc, w_sel_oc);
    end
    drv_mode = 0;
    mon_on = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    l = '{3, 2, 4, 1};
    test_stream("after_rst", l, 2, 2, 2);
  endtask

  task automatic test_start_ignored();
    lens_t l;
    bit ok;
    bit hit;
    int nw;
    l = '{2, 1, 0, 1};
    build_exp(l, 3);
    clear_mon();
    drv_mode = 2;
    do_start(l, 3);
    hit = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      if (n_xwr > 0) begin
        hit = 1'b1;
        break;
      end
    end
    w_len = {NW{WA'(7)}};
    x_len = XA'(7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_en(ok);
    drv_mode = 0;
    n_chk++;
    if ({hit, ok} !== 2'b11) begin
      n_fail++;
      $display("FAIL ign_events: in_x/en_up %b want 11", {hit, ok});
    end
    n_chk++;
    if (obs.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL ign_n_writes: got %0d want %0d",
               obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size()
                    && i < beats.size(); i++) begin
      n_chk++;
      if (obs[i].x !== exp_q[i].x || obs[i].sel !== exp_q[i].sel ||
          obs[i].addr !== exp_q[i].addr || obs[i].d !== beats[i]) begin
        n_fail++;
        $display("FAIL ign_wr[%0d]: got x%0d s%0d a%0d d%0d want x%0d s%0d a%0d d%0d",
                 i, obs[i].x, obs[i].sel, obs[i].addr, obs[i].d,
                 exp_q[i].x, exp_q[i].sel, exp_q[i].addr, beats[i]);
      end
    end
    nw = obs.size();
    start = 1'b1;
    drv_mode = 1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_chk++;
    if ({busy, en_compute, load_compute_ctrl, sif.s_ready} !== 4'b1100)
    begin
      n_fail++;
      $display("FAIL ign_compute: busy/en/lcc/rdy %b want 1100",
               {busy, en_compute, load_compute_ctrl, sif.s_ready});
    end
    drv_mode = 0;
    compute_finish = 1'b1;
    @(negedge clk);
    #1;
    compute_finish = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({busy, done_cnt, obs.size()} !== {1'b0, 32'sd1, nw}) begin
      n_fail++;
      $display("FAIL ign_end: busy %b done_cnt %0d writes %0d want 0 1 %0d",
               busy, done_cnt, obs.size(), nw);
    end
    mon_on = 1'b0;
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    start          = 1'b0;
    w_len          = '0;
    x_len          = '0;
    compute_finish = 1'b0;
    drv_mode       = 0;
    mon_on         = 1'b0;
    rst            = 1'b1;
    test_reset();
    test_full_stream();
    test_random_valid();
    test_skip_banks();
    test_random_lengths();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
